// File: rtl/stage_sequencer.sv
// Three-stage job sequencer (A -> B -> C) with one-deep pending start, abort and job counter.
// Define STAGE_SEQUENCER_WATCHDOG_EN to build the per-stage watchdog and the ERROR state.
module stage_sequencer #(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       done_a,
  input  logic       done_b,
  input  logic       done_c,
  output logic       go_a,
  output logic       go_b,
  output logic       go_c,
  output logic       busy,
  output logic       Done,
  output logic       err,
  output logic [1:0] err_code,
  output logic [7:0] job_count,
  output logic [2:0] state_o
);

  if (TIMEOUT < 1 || TIMEOUT > (1 << TIMEOUT_W) - 1) begin : g_bad_timeout
    $error("stage_sequencer: TIMEOUT out of range for TIMEOUT_W");
  end

  // RUN_A..RUN_C encodings double as the err_code of the stage that timed out.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN_A  = 3'd1,
    RUN_B  = 3'd2,
    RUN_C  = 3'd3,
    FINISH = 3'd4
`ifdef STAGE_SEQUENCER_WATCHDOG_EN
    , ERROR = 3'd5
`endif
  } state_e;

  state_e     state_q, state_d;
  logic       pending_q, pending_d;
  logic       go_a_q, go_a_d;
  logic       go_b_q, go_b_d;
  logic       go_c_q, go_c_d;
  logic       busy_q;
  logic       done_q;
  logic [7:0] job_count_q, job_count_d;
  logic       stage_done;
  logic       run_state;

  assign run_state = (state_q == RUN_A) || (state_q == RUN_B) || (state_q == RUN_C);

  always_comb begin
    stage_done = 1'b0;
    case (state_q)
      RUN_A:   stage_done = done_a;
      RUN_B:   stage_done = done_b;
      RUN_C:   stage_done = done_c;
      default: stage_done = 1'b0;
    endcase
  end

`ifdef STAGE_SEQUENCER_WATCHDOG_EN
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 wd_expired;
  logic                 err_q;
  logic [1:0]           err_code_q, err_code_d;

  assign wd_expired = (wd_q == TIMEOUT_W'(TIMEOUT - 1));
`endif

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    go_a_d      = 1'b0;
    go_b_d      = 1'b0;
    go_c_d      = 1'b0;
    job_count_d = job_count_q;
`ifdef STAGE_SEQUENCER_WATCHDOG_EN
    err_code_d  = err_code_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN_A;
          go_a_d  = 1'b1;
        end
      end
      RUN_A, RUN_B, RUN_C: begin
        if (start) pending_d = 1'b1;
        if (abort) begin
          state_d   = IDLE;
          pending_d = 1'b0;
        end else if (stage_done) begin
          case (state_q)
            RUN_A:   begin state_d = RUN_B; go_b_d = 1'b1; end
            RUN_B:   begin state_d = RUN_C; go_c_d = 1'b1; end
            default: state_d = FINISH;
          endcase
        end
      end
      FINISH: begin
        // A start landing in this very cycle counts as the pending request.
        if (abort) begin
          state_d   = IDLE;
          pending_d = 1'b0;
        end else if (pending_q || start) begin
          state_d   = RUN_A;
          go_a_d    = 1'b1;
          pending_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
`ifdef STAGE_SEQUENCER_WATCHDOG_EN
      ERROR: begin
        if (start) begin
          state_d    = RUN_A;
          go_a_d     = 1'b1;
          err_code_d = 2'd0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

`ifdef STAGE_SEQUENCER_WATCHDOG_EN
    if (run_state && !abort && !stage_done && wd_expired) begin
      state_d    = ERROR;
      pending_d  = 1'b0;
      err_code_d = state_q[1:0];
    end
    wd_d = (run_state && state_d == state_q) ? wd_q + 1'b1 : '0;
`endif

    if (state_d == FINISH) job_count_d = job_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      pending_q   <= 1'b0;
      go_a_q      <= 1'b0;
      go_b_q      <= 1'b0;
      go_c_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      job_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      go_a_q      <= go_a_d;
      go_b_q      <= go_b_d;
      go_c_q      <= go_c_d;
      busy_q      <= (state_d == RUN_A) || (state_d == RUN_B) ||
                     (state_d == RUN_C) || (state_d == FINISH);
      done_q      <= (state_d == FINISH);
      job_count_q <= job_count_d;
    end
  end

`ifdef STAGE_SEQUENCER_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_q       <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      wd_q       <= wd_d;
      err_q      <= (state_d == ERROR);
      err_code_q <= err_code_d;
    end
  end

  assign err      = err_q;
  assign err_code = err_code_q;
`else
  assign err      = 1'b0;
  assign err_code = 2'd0;
`endif

  assign go_a      = go_a_q;
  assign go_b      = go_b_q;
  assign go_c      = go_c_q;
  assign busy      = busy_q;
  assign Done      = done_q;
  assign job_count = job_count_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: vector table, directed multi-cycle sequences and random
// stimulus checked cycle by cycle against a job-level reference model.
module tb_stage_sequencer;

  localparam int TIMEOUT = 4;
`ifdef STAGE_SEQUENCER_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  localparam int GAP = WD_EN ? 2 : 4;

  logic       clk = 1'b0;
  logic       reset, start, abort, done_a, done_b, done_c;
  logic       go_a, go_b, go_c, busy, Done, err;
  logic [1:0] err_code;
  logic [7:0] job_count;
  logic [2:0] state_o;
  logic [15:0] dut_word;

  int n_checks = 0;
  int n_errors = 0;
  int n_go_a, n_go_b, n_go_c, n_done;

  logic [15:0] exp_q[$];

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout act=stuck exp=finished");
    $fatal(1, "bench time limit expired");
  end

  stage_sequencer #(.TIMEOUT_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .done_a(done_a), .done_b(done_b), .done_c(done_c),
    .go_a(go_a), .go_b(go_b), .go_c(go_c), .busy(busy), .Done(Done),
    .err(err), .err_code(err_code), .job_count(job_count), .state_o(state_o)
  );

  assign dut_word = {go_c, go_b, go_a, busy, Done, err, err_code, job_count};

  // ---------------- reference model ----------------
  // Phase: 0 idle, 1..3 running stage A..C, 4 finish, 5 error.
  int         m_ph;
  bit         m_pend;
  logic [7:0] m_cnt;
  logic [1:0] m_code;
  int         m_wd;
  logic [2:0] m_go;

  task automatic model_step(input bit r, input bit s, input bit a, input logic [2:0] dn);
    int prev;
    prev = m_ph;
    if (!r) begin
      m_ph = 0; m_pend = 0; m_cnt = 0; m_code = 0; m_wd = 0; m_go = 0;
      return;
    end
    case (m_ph)
      0: if (s) m_ph = 1;
      1, 2, 3: begin
        if (s) m_pend = 1;
        if (a) begin
          m_ph = 0; m_pend = 0;
        end else if (dn[m_ph-1]) begin
          m_ph = m_ph + 1;
        end else begin
          m_wd++;
          if (WD_EN && m_wd == TIMEOUT) begin
            m_code = 2'(m_ph); m_ph = 5; m_pend = 0;
          end
        end
      end
      4: begin
        if (a) begin m_ph = 0; m_pend = 0; end
        else if (m_pend || s) begin m_ph = 1; m_pend = 0; end
        else m_ph = 0;
      end
      5: if (s) begin m_ph = 1; m_code = 0; end
      default: m_ph = 0;
    endcase
    m_go = 3'b000;
    if (m_ph != prev && m_ph >= 1 && m_ph <= 3) begin
      m_wd = 0;
      m_go[m_ph-1] = 1'b1;
    end
    if (m_ph == 4) m_cnt = m_cnt + 8'd1;
  endtask

  function automatic logic [15:0] model_word();
    return {m_go, (m_ph >= 1 && m_ph <= 4), (m_ph == 4), (m_ph == 5), m_code, m_cnt};
  endfunction

  function automatic logic [15:0] ew(input logic [2:0] go, input bit b, input bit d,
                                     input logic [7:0] cnt);
    return {go, b, d, 1'b0, 2'b00, cnt};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act go=%b busy=%b done=%b err=%b code=%0d cnt=%0d exp go=%b busy=%b done=%b err=%b code=%0d cnt=%0d",
               name, act[15:13], act[12], act[11], act[10], act[9:8], act[7:0],
               exp[15:13], exp[12], exp[11], exp[10], exp[9:8], exp[7:0]);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%b exp=%b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit r, input bit s, input bit a, input bit da, input bit db, input bit dc);
    reset = r; start = s; abort = a; done_a = da; done_b = db; done_c = dc;
  endtask

  task automatic cycle(input bit r, input bit s, input bit a, input bit da, input bit db, input bit dc);
    drive(r, s, a, da, db, dc);
    @(posedge clk);
    model_step(r, s, a, {dc, db, da});
    exp_q.push_back(model_word());
    #1;
    check("model_cycle", dut_word, exp_q.pop_front());
    n_go_a += int'(go_a); n_go_b += int'(go_b); n_go_c += int'(go_c); n_done += int'(Done);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0);
  endtask

  task automatic clear_counts();
    n_go_a = 0; n_go_b = 0; n_go_c = 0; n_done = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          r, s, a, da, db, dc;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mkv(input bit r, input bit s, input bit a, input bit da, input bit db,
                               input bit dc, input logic [15:0] exp);
    vec_t v;
    v.r = r; v.s = s; v.a = a; v.da = da; v.db = db; v.dc = dc; v.exp = exp;
    return v;
  endfunction

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    clear_counts();

    tbl[0]  = mkv(0, 0, 0, 0, 0, 0, ew(3'b000, 0, 0, 8'd0));
    tbl[1]  = mkv(1, 1, 0, 0, 0, 0, ew(3'b001, 1, 0, 8'd0));
    tbl[2]  = mkv(1, 0, 0, 1, 0, 0, ew(3'b010, 1, 0, 8'd0));
    tbl[3]  = mkv(1, 0, 0, 0, 1, 0, ew(3'b100, 1, 0, 8'd0));
    tbl[4]  = mkv(1, 0, 0, 0, 0, 1, ew(3'b000, 1, 1, 8'd1));
    tbl[5]  = mkv(1, 0, 0, 0, 0, 0, ew(3'b000, 0, 0, 8'd1));
    tbl[6]  = mkv(1, 0, 0, 0, 1, 1, ew(3'b000, 0, 0, 8'd1));
    tbl[7]  = mkv(1, 1, 0, 0, 0, 0, ew(3'b001, 1, 0, 8'd1));
    tbl[8]  = mkv(1, 0, 0, 0, 1, 1, ew(3'b000, 1, 0, 8'd1));
    tbl[9]  = mkv(1, 0, 0, 1, 0, 0, ew(3'b010, 1, 0, 8'd1));
    tbl[10] = mkv(1, 1, 0, 0, 1, 0, ew(3'b100, 1, 0, 8'd1));
    tbl[11] = mkv(1, 0, 1, 0, 0, 1, ew(3'b000, 0, 0, 8'd1));
    tbl[12] = mkv(1, 0, 0, 0, 0, 0, ew(3'b000, 0, 0, 8'd1));
    tbl[13] = mkv(1, 1, 0, 0, 0, 0, ew(3'b001, 1, 0, 8'd1));
    tbl[14] = mkv(1, 0, 0, 1, 0, 0, ew(3'b010, 1, 0, 8'd1));
    tbl[15] = mkv(1, 0, 0, 0, 1, 0, ew(3'b100, 1, 0, 8'd1));
    tbl[16] = mkv(1, 0, 0, 0, 0, 1, ew(3'b000, 1, 1, 8'd2));
    tbl[17] = mkv(1, 0, 0, 0, 0, 0, ew(3'b000, 0, 0, 8'd2));

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].a, tbl[i].da, tbl[i].db, tbl[i].dc);
      @(posedge clk);
      model_step(tbl[i].r, tbl[i].s, tbl[i].a, {tbl[i].dc, tbl[i].db, tbl[i].da});
      #1;
      check($sformatf("vec%0d", i), dut_word, tbl[i].exp);
    end

    // Spaced stage completions: one pulse of each go, one Done.
    cycle(0, 0, 0, 0, 0, 0);
    clear_counts();
    cycle(1, 1, 0, 0, 0, 0);
    idle(GAP); cycle(1, 0, 0, 1, 0, 0);
    idle(GAP); cycle(1, 0, 0, 0, 1, 0);
    idle(GAP); cycle(1, 0, 0, 0, 0, 1);
    idle(2);
    check_int("spaced_go_a_pulses", n_go_a, 1);
    check_int("spaced_go_b_pulses", n_go_b, 1);
    check_int("spaced_go_c_pulses", n_go_c, 1);
    check_int("spaced_done_pulses", n_done, 1);
    check_int("spaced_job_count", int'(job_count), 1);
    check_bit("spaced_busy_low", busy, 1'b0);

    // Two starts during RUN_B: one back-to-back job, the second start dropped.
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0, 1);
    check_bit("b2b_done", Done, 1'b1);
    cycle(1, 0, 0, 0, 0, 0);
    check_bit("b2b_go_a_next", go_a, 1'b1);
    cycle(1, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0, 1);
    idle(2);
    check_int("b2b_job_count", int'(job_count), 2);
    check_bit("b2b_no_third_job", busy, 1'b0);

    // 256 jobs wrap the counter.
    cycle(0, 0, 0, 0, 0, 0);
    for (int j = 0; j < 256; j++) begin
      cycle(1, 1, 0, 0, 0, 0);
      cycle(1, 0, 0, 1, 0, 0);
      cycle(1, 0, 0, 0, 1, 0);
      cycle(1, 0, 0, 0, 0, 1);
      cycle(1, 0, 0, 0, 0, 0);
      if (j == 254) check_int("wrap_count_255", int'(job_count), 255);
    end
    check_int("wrap_count_0", int'(job_count), 0);

    // Reset in RUN_B clears every output on the next cycle.
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 1, 0);
    check("reset_mid_run_b", dut_word, 16'h0000);

`ifdef STAGE_SEQUENCER_WATCHDOG_EN
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 0);
    idle(3);
    check_bit("wd_still_busy", busy, 1'b1);
    cycle(1, 0, 0, 0, 0, 0);
    check("wd_error_b", dut_word, {3'b000, 1'b0, 1'b0, 1'b1, 2'd2, 8'd0});
    idle(2);
    check_bit("wd_err_sticky", err, 1'b1);
    cycle(1, 1, 0, 0, 0, 0);
    check("wd_restart", dut_word, ew(3'b001, 1, 0, 8'd0));
    cycle(1, 0, 0, 1, 0, 0);
    idle(3);
    cycle(1, 0, 0, 0, 1, 0);
    check("wd_done_on_limit", dut_word, ew(3'b100, 1, 0, 8'd0));
    cycle(1, 0, 0, 0, 0, 1);
`else
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 0);
    idle(12);
    check("stall_no_watchdog", dut_word, ew(3'b000, 1, 0, 8'd0));
    cycle(1, 0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0, 1);
`endif
    idle(1);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) != 0,
            $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 30);
    end

    check_int("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
